// File: rtl/branch_predict_ctrl_if.sv
// Bus between the pipeline and branch_predict_ctrl.
// Fetch side:
//   pred_pc -> pred_taken
// Execute side:
//   res_valid, res_pc, res_pred_taken, res_miss, res_target, res_fallthru
// Recovery side:
//   redirect_valid, redirect_pc, flush
// Statistics:
//   branch_cnt, miss_cnt
// Modports:
//   master - pipeline side
//   slave  - controller side
interface branch_predict_ctrl_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic            res_valid;
    logic [PC_W-1:0] res_pc;
    logic            res_pred_taken;
    logic            res_miss;
    logic [PC_W-1:0] res_target;
    logic [PC_W-1:0] res_fallthru;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush;
    logic [15:0]     branch_cnt;
    logic [15:0]     miss_cnt;

    modport master (
        output pred_pc, res_valid, res_pc, res_pred_taken, res_miss,
               res_target, res_fallthru,
        input  pred_taken, redirect_valid, redirect_pc, flush,
               branch_cnt, miss_cnt
    );

    modport slave (
        input  pred_pc, res_valid, res_pc, res_pred_taken, res_miss,
               res_target, res_fallthru,
        output pred_taken, redirect_valid, redirect_pc, flush,
               branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Branch predictor and misprediction recovery controller.
//
// Prediction:
//   A table of 2-bit saturating counters, indexed by PC[IDX_W-1:0].
//   It predicts the fetch PC combinationally.
// Training:
//   The table is trained from execute-stage resolutions.
// Recovery:
//   A miss produces a one-cycle registered redirect.
//   It also holds flush for FLUSH_CYCLES cycles.
//   Resolutions arriving during the flush are wrong-path and are ignored.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high reset
//   bus - branch_predict_ctrl_if.slave: prediction, resolution, recovery, stats
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting resolutions; a miss loads the flush counter
// FLUSH | flush asserted; counter counts down; res_valid ignored
module branch_predict_ctrl #(
    parameter int IDX_W        = 4,
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_ctrl_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [1:0]        table_q [ENTRIES];
    logic              accept;
    logic              act;
    logic [IDX_W-1:0]  ridx;
    logic              redirect_valid_q;
    logic [PC_W-1:0]   redirect_pc_q;
    logic [15:0]       branch_cnt_q;
    logic [15:0]       miss_cnt_q;
    logic              unused_pc_bits;

    assign accept = (state_q == IDLE) && bus.res_valid;
    assign act    = bus.res_pred_taken ^ bus.res_miss;
    assign ridx   = bus.res_pc[IDX_W-1:0];

    // The table read is taken from the registered array.
    // A same-cycle update to the same index is therefore not visible yet.
    assign bus.pred_taken     = table_q[bus.pred_pc[IDX_W-1:0]][1];
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = (state_q == FLUSH);
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.miss_cnt       = miss_cnt_q;

    // Upper PC bits alias into the table and are intentionally dropped.
    assign unused_pc_bits = ^{bus.pred_pc[PC_W-1:IDX_W], bus.res_pc[PC_W-1:IDX_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (accept && bus.res_miss) begin
                    state_d = FLUSH;
                    fcnt_d  = 3'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                // Leaving at a count of 1 gives exactly FLUSH_CYCLES cycles in FLUSH.
                if (fcnt_q == 3'd1) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
        end else if (accept) begin
            if (act) begin
                if (table_q[ridx] != 2'b11) begin
                    table_q[ridx] <= table_q[ridx] + 2'b01;
                end
            end else begin
                if (table_q[ridx] != 2'b00) begin
                    table_q[ridx] <= table_q[ridx] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= accept && bus.res_miss;
            if (accept && bus.res_miss) begin
                redirect_pc_q <= act ? bus.res_target : bus.res_fallthru;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else if (accept) begin
            if (branch_cnt_q != 16'hFFFF) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (bus.res_miss && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] exp_q [$];
    logic [15:0] sb_exp;

    always #5 clk = ~clk;

    branch_predict_ctrl_if #(.PC_W(16)) bus ();

    branch_predict_ctrl #(.IDX_W(4), .PC_W(16), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [15:0] pc, input logic exp, input string tag);
        bus.pred_pc = pc;
        #1;
        check(tag, {31'd0, bus.pred_taken}, {31'd0, exp});
    endtask

    task automatic res(input logic [15:0] pc, input logic pt, input logic miss,
                       input logic [15:0] tgt, input logic [15:0] ft);
        bus.res_valid      = 1'b1;
        bus.res_pc         = pc;
        bus.res_pred_taken = pt;
        bus.res_miss       = miss;
        bus.res_target     = tgt;
        bus.res_fallthru   = ft;
    endtask

    // Scoreboard: each redirect pulse must match the oldest expected target.
    always @(negedge clk) begin
        if (!rst && bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("redirect_unexpected", {31'd0, bus.redirect_valid}, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("redirect_pc_sb", {16'd0, bus.redirect_pc}, {16'd0, sb_exp});
            end
        end
    end

    initial begin
        rst                = 1'b1;
        bus.pred_pc        = '0;
        bus.res_valid      = 1'b0;
        bus.res_pc         = '0;
        bus.res_pred_taken = 1'b0;
        bus.res_miss       = 1'b0;
        bus.res_target     = '0;
        bus.res_fallthru   = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("rst_redirect_pc", {16'd0, bus.redirect_pc}, 32'd0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_branch_cnt", {16'd0, bus.branch_cnt}, 32'd0);
        check("rst_miss_cnt", {16'd0, bus.miss_cnt}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            peek(16'(i), 1'b0, "rst_sweep_pred");
            tick();
        end

        // Three correct taken resolutions at index 5: 01 -> 10 -> 11 -> 11
        res(16'h0005, 1'b1, 1'b0, 16'h0000, 16'h0006);
        tick();
        peek(16'h0005, 1'b1, "train5_first");
        tick();
        tick();
        bus.res_valid = 1'b0;
        check("train5_branch_cnt", {16'd0, bus.branch_cnt}, 32'd3);
        check("train5_flush", {31'd0, bus.flush}, 32'd0);
        check("train5_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        peek(16'h0015, 1'b1, "alias_0x15");

        // Miss: not-taken predicted, actually taken -> redirect to target
        res(16'h0010, 1'b0, 1'b1, 16'h0040, 16'h0011);
        exp_q.push_back(16'h0040);
        tick();
        check("miss1_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("miss1_redirect_pc", {16'd0, bus.redirect_pc}, 32'h40);
        check("miss1_flush_n1", {31'd0, bus.flush}, 32'd1);
        check("miss1_miss_cnt", {16'd0, bus.miss_cnt}, 32'd1);
        check("miss1_branch_cnt", {16'd0, bus.branch_cnt}, 32'd4);
        // Wrong-path miss during flush: must be dropped
        res(16'h0010, 1'b0, 1'b1, 16'h0099, 16'h0011);
        tick();
        bus.res_valid = 1'b0;
        check("drop_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("drop_flush_n2", {31'd0, bus.flush}, 32'd1);
        check("drop_branch_cnt", {16'd0, bus.branch_cnt}, 32'd4);
        check("drop_miss_cnt", {16'd0, bus.miss_cnt}, 32'd1);
        tick();
        check("miss1_flush_n3", {31'd0, bus.flush}, 32'd0);
        check("miss1_redirect_n3", {31'd0, bus.redirect_valid}, 32'd0);
        peek(16'h0010, 1'b1, "entry0_after_miss");

        // Miss right after flush drops: taken predicted, actually not-taken
        res(16'h0003, 1'b1, 1'b1, 16'h0077, 16'h0004);
        exp_q.push_back(16'h0004);
        tick();
        bus.res_valid = 1'b0;
        check("miss2_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("miss2_redirect_pc", {16'd0, bus.redirect_pc}, 32'h4);
        check("miss2_flush", {31'd0, bus.flush}, 32'd1);
        check("miss2_miss_cnt", {16'd0, bus.miss_cnt}, 32'd2);
        check("miss2_branch_cnt", {16'd0, bus.branch_cnt}, 32'd5);
        peek(16'h0003, 1'b0, "entry3_after_miss2");
        tick();
        tick();
        check("miss2_flush_done", {31'd0, bus.flush}, 32'd0);

        // Entry 0 must be 10 (dropped miss did not train): one not-taken -> 01
        res(16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0001);
        tick();
        bus.res_valid = 1'b0;
        peek(16'h0000, 1'b0, "entry0_untrained_by_drop");
        check("nt_branch_cnt", {16'd0, bus.branch_cnt}, 32'd6);
        check("nt_flush", {31'd0, bus.flush}, 32'd0);

        // Same index read and written in the same cycle
        res(16'h0007, 1'b1, 1'b0, 16'h0000, 16'h0008);
        peek(16'h0007, 1'b0, "same_idx_pre");
        tick();
        bus.res_valid = 1'b0;
        peek(16'h0007, 1'b1, "same_idx_post");
        check("same_idx_branch_cnt", {16'd0, bus.branch_cnt}, 32'd7);

        // Reset during the first flush cycle
        res(16'h0009, 1'b0, 1'b1, 16'h0123, 16'h000A);
        exp_q.push_back(16'h0123);
        tick();
        bus.res_valid = 1'b0;
        check("rstmid_flush_before", {31'd0, bus.flush}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_flush_async", {31'd0, bus.flush}, 32'd0);
        check("rstmid_branch_cnt", {16'd0, bus.branch_cnt}, 32'd0);
        peek(16'h0005, 1'b0, "rstmid_entry5");
        peek(16'h0007, 1'b0, "rstmid_entry7");
        rst = 1'b0;
        res(16'h0002, 1'b1, 1'b0, 16'h0000, 16'h0003);
        tick();
        bus.res_valid = 1'b0;
        peek(16'h0002, 1'b1, "post_rst_accept");
        check("post_rst_branch_cnt", {16'd0, bus.branch_cnt}, 32'd1);
        check("post_rst_flush", {31'd0, bus.flush}, 32'd0);
        tick();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
